// File: rtl/obi_mem_responder_pkg.sv
// Shared types, constants and helpers for the OBI memory responder.
package obi_mem_responder_pkg;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_resp_t;

  localparam int unsigned BYTE_LANES       = 4;
  localparam int unsigned WORD_OFFSET_BITS = 2;

  // True when a byte address falls inside a memory of mem_depth words.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input int unsigned mem_depth);
    return addr < (64'(mem_depth) << WORD_OFFSET_BITS);
  endfunction

endpackage

// File: rtl/obi_resp_fifo.sv
// In-order response FIFO; each entry carries a countdown that must reach
// zero before the entry may be presented at the head.
module obi_resp_fifo
  import obi_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  obi_resp_t push_data_i,
  input  logic      pop_i,
  output logic      head_valid_o,
  output obi_resp_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LW-1:0] LAT_INIT = LW'(LATENCY - 1);

  obi_resp_t         data_q [DEPTH];
  logic [LW-1:0]     lat_q  [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage, countdowns, pointers and occupancy count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        lat_q[i]  <= '0;
      end
    end else begin
      // Ageing every slot is harmless for empty ones; a push overwrites its slot below.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (lat_q[i] != '0) lat_q[i] <= lat_q[i] - LW'(1);
      end
      if (push_i) begin
        data_q[wr_ptr_q] <= push_data_i;
        lat_q[wr_ptr_q]  <= LAT_INIT;
        wr_ptr_q         <= next_ptr(wr_ptr_q);
      end
      if (pop_i) rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == CW'(DEPTH));
  assign head_valid_o = !empty_o && (lat_q[rd_ptr_q] == '0);
  assign head_o       = data_q[rd_ptr_q];

endmodule

// File: rtl/obi_mem_responder.sv
// OBI memory slave: byte-enabled word memory with in-order, latency-
// delayed responses and rready backpressure.
module obi_mem_responder
  import obi_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MEM_DEPTH       = 1024,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned RESP_LATENCY    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o
);

  localparam int unsigned IW = $clog2(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [IW-1:0] word_idx;
  logic          in_range;
  logic          accept;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          head_valid;
  obi_resp_t     head;
  obi_resp_t     push_data;

  assign word_idx = addr_i[IW+WORD_OFFSET_BITS-1:WORD_OFFSET_BITS];
  assign in_range = addr_in_range(64'(addr_i), MEM_DEPTH);
  assign pop      = head_valid && rready_i;
  assign gnt_o    = req_i && !rst_i && (!fifo_full || pop);
  assign accept   = req_i && gnt_o;

  // Response entry captured at the accepting edge; reads see prior writes.
  always_comb begin
    push_data = '0;
    if (!in_range) begin
      push_data.err = 1'b1;
    end else if (!we_i) begin
      push_data.rdata = mem[word_idx];
    end
  end

  // Byte-lane writes; memory contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (accept && we_i && in_range) begin
      for (int unsigned i = 0; i < BYTE_LANES; i++) begin
        if (be_i[i]) mem[word_idx][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  obi_resp_fifo #(
    .DEPTH   (MAX_OUTSTANDING),
    .LATENCY (RESP_LATENCY)
  ) u_resp_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (accept),
    .push_data_i  (push_data),
    .pop_i        (pop),
    .head_valid_o (head_valid),
    .head_o       (head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  assign rvalid_o = head_valid && !fifo_empty;
  assign rdata_o  = rvalid_o ? head.rdata : '0;
  assign err_o    = rvalid_o ? head.err   : 1'b0;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Scoreboard bench for obi_mem_responder (latency 1 and latency 3 instances).
module tb_obi_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, rready;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;

  logic        req3, we3, rready3;
  logic [31:0] addr3, wdata3;
  logic [3:0]  be3;
  logic        gnt3, rvalid3, err3;
  logic [31:0] rdata3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model [int unsigned];

  always #5 clk = ~clk;

  obi_mem_responder #(
    .MEM_DEPTH       (1024),
    .MAX_OUTSTANDING (4),
    .RESP_LATENCY    (1)
  ) dut (
    .clk_i (clk), .rst_i (rst), .req_i (req), .gnt_o (gnt), .addr_i (addr),
    .we_i (we), .be_i (be), .wdata_i (wdata), .rvalid_o (rvalid),
    .rready_i (rready), .rdata_o (rdata), .err_o (err)
  );

  obi_mem_responder #(
    .MEM_DEPTH       (1024),
    .MAX_OUTSTANDING (4),
    .RESP_LATENCY    (3)
  ) dut3 (
    .clk_i (clk), .rst_i (rst), .req_i (req3), .gnt_o (gnt3), .addr_i (addr3),
    .we_i (we3), .be_i (be3), .wdata_i (wdata3), .rvalid_o (rvalid3),
    .rready_i (rready3), .rdata_o (rdata3), .err_o (err3)
  );

  // Reference model: compute the response for an accepted request.
  function automatic void expect_push(input logic w, input logic [31:0] a,
                                      input logic [3:0] b, input logic [31:0] d);
    exp_t        e;
    int unsigned idx;
    logic [31:0] cur;
    e.rdata = '0;
    e.err   = 1'b0;
    idx     = int'(a[11:2]);
    if (a >= 32'h1000) begin
      e.err = 1'b1;
    end else if (w) begin
      cur = model.exists(idx) ? model[idx] : 32'h0;
      for (int i = 0; i < 4; i++) if (b[i]) cur[8*i +: 8] = d[8*i +: 8];
      model[idx] = cur;
    end else begin
      e.rdata = model.exists(idx) ? model[idx] : 32'h0;
    end
    sb.push_back(e);
  endfunction

  // Monitor: compare every completed response handshake with the scoreboard.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rvalid === 1'b1 && rready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected got rdata %h err %b expected no response", rdata, err);
      end else begin
        e = sb.pop_front();
        if (rdata !== e.rdata || err !== e.err) begin
          errors++;
          $display("FAIL resp got rdata %h err %b expected rdata %h err %b",
                   rdata, err, e.rdata, e.err);
        end
      end
    end
  end

  task automatic xfer(input logic w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      req = 1'b1; we = w; addr = a; be = b; wdata = d;
      #1;
      if (gnt === 1'b1) begin
        expect_push(w, a, b, d);
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL xfer_grant got no grant expected grant for addr %h", a);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    for (int n = 0; n < 30 && !empty; n++) begin
      @(negedge clk);
      #3;
      if (sb.size() == 0) empty = 1'b1;
    end
    checks++;
    if (!empty) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h0; be = 4'hF; wdata = '0; rready = 1'b1;
    req3 = 1'b1; we3 = 1'b0; addr3 = 32'h0; be3 = 4'hF; wdata3 = '0; rready3 = 1'b1;
    #3;
    checks++;
    if ({gnt, rvalid, rdata, err} !== 35'h0) begin
      errors++;
      $display("FAIL reset_outputs got gnt %b rvalid %b rdata %h err %b expected all 0",
               gnt, rvalid, rdata, err);
    end
    checks++;
    if ({gnt3, rvalid3, rdata3, err3} !== 35'h0) begin
      errors++;
      $display("FAIL reset_outputs3 got gnt %b rvalid %b rdata %h err %b expected all 0",
               gnt3, rvalid3, rdata3, err3);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0; req = 1'b0; req3 = 1'b0;
  endtask

  task automatic test_write_read();
    xfer(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    xfer(1'b0, 32'h10, 4'hF, 32'h0);
    idle();
    #1;
    checks++;
    if (rvalid !== 1'b1) begin
      errors++;
      $display("FAIL read_latency1 got rvalid %b expected 1", rvalid);
    end
    drain();
  endtask

  task automatic test_partial_be();
    xfer(1'b1, 32'h20, 4'hF, 32'h11223344);
    xfer(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
    xfer(1'b0, 32'h20, 4'hF, 32'h0);
    idle();
    drain();
  endtask

  task automatic test_full();
    logic [31:0] list [6];
    int          k, grants;
    bit          seen;
    logic [31:0] held;
    list[0] = 32'h10; list[1] = 32'h20; list[2] = 32'h10;
    list[3] = 32'h20; list[4] = 32'h10; list[5] = 32'h20;
    k = 0; grants = 0; seen = 1'b0; held = '0;
    rready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req = 1'b1; we = 1'b0; be = 4'hF; addr = list[k];
      #1;
      if (seen) begin
        checks++;
        if (rvalid !== 1'b1 || rdata !== held) begin
          errors++;
          $display("FAIL hold_stable got rvalid %b rdata %h expected 1 %h", rvalid, rdata, held);
        end
      end else if (rvalid === 1'b1) begin
        seen = 1'b1;
        held = rdata;
      end
      if (gnt === 1'b1) begin
        expect_push(1'b0, list[k], 4'hF, 32'h0);
        k++;
        grants++;
      end
    end
    checks++;
    if (grants != 4 || gnt !== 1'b0) begin
      errors++;
      $display("FAIL full_grants got %0d gnt %b expected 4 gnt 0", grants, gnt);
    end
    @(negedge clk);
    rready = 1'b1;
    addr = list[k];
    #1;
    checks++;
    if (gnt !== 1'b1) begin
      errors++;
      $display("FAIL grant_on_pop got gnt %b expected 1", gnt);
    end
    if (gnt === 1'b1) begin
      expect_push(1'b0, list[k], 4'hF, 32'h0);
      k++;
    end
    while (k < 6) begin
      xfer(1'b0, list[k], 4'hF, 32'h0);
      k++;
    end
    idle();
    drain();
  endtask

  task automatic test_out_of_range();
    xfer(1'b1, 32'h0, 4'hF, 32'h0BADF00D);
    xfer(1'b0, 32'h1000, 4'hF, 32'h0);
    xfer(1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF);
    xfer(1'b0, 32'h0, 4'hF, 32'h0);
    idle();
    drain();
  endtask

  task automatic test_latency();
    logic [5:0] pat;
    @(negedge clk);
    req3 = 1'b1; we3 = 1'b1; addr3 = 32'h40; be3 = 4'hF; wdata3 = 32'h12345678;
    #1;
    checks++;
    if (gnt3 !== 1'b1) begin
      errors++;
      $display("FAIL lat_write_gnt got %b expected 1", gnt3);
    end
    @(negedge clk);
    req3 = 1'b0;
    repeat (4) @(negedge clk);
    req3 = 1'b1; we3 = 1'b0; addr3 = 32'h40;
    #1;
    checks++;
    if (gnt3 !== 1'b1) begin
      errors++;
      $display("FAIL lat_read_gnt got %b expected 1", gnt3);
    end
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req3 = 1'b0;
      #1;
      pat[i] = rvalid3;
      if (rvalid3 === 1'b1) begin
        checks++;
        if (rdata3 !== 32'h12345678 || err3 !== 1'b0) begin
          errors++;
          $display("FAIL lat_rdata got %h err %b expected 12345678 0", rdata3, err3);
        end
      end
    end
    checks++;
    if (pat[3:0] !== 4'b0100) begin
      errors++;
      $display("FAIL lat_single got pattern %b expected 0100", pat[3:0]);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req3 = 1'b1; we3 = 1'b0; addr3 = 32'h40;
      #1;
      checks++;
      if (gnt3 !== 1'b1) begin
        errors++;
        $display("FAIL lat_b2b_gnt got %b expected 1", gnt3);
      end
    end
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req3 = 1'b0;
      #1;
      pat[i] = rvalid3;
      if (rvalid3 === 1'b1 && rdata3 !== 32'h12345678) begin
        checks++;
        errors++;
        $display("FAIL lat_b2b_rdata got %h expected 12345678", rdata3);
      end
    end
    checks++;
    if (pat !== 6'b000111) begin
      errors++;
      $display("FAIL lat_b2b got pattern %b expected 000111", pat);
    end
  endtask

  task automatic test_reset_mid();
    bit stale;
    rready = 1'b0;
    for (int i = 0; i < 3; i++) xfer(1'b0, 32'h10, 4'hF, 32'h0);
    @(negedge clk);
    req = 1'b0;
    #1;
    checks++;
    if (rvalid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pending got rvalid %b expected 1", rvalid);
    end
    #2;
    rst = 1'b1;
    req = 1'b1; we = 1'b0; addr = 32'h10;
    #1;
    checks++;
    if (rvalid !== 1'b0 || gnt !== 1'b0) begin
      errors++;
      $display("FAIL mid_async got rvalid %b gnt %b expected 0 0", rvalid, gnt);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0; req = 1'b0; rready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (rvalid !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      errors++;
      $display("FAIL mid_stale got rvalid 1 expected 0 after reset");
    end
    xfer(1'b0, 32'h10, 4'hF, 32'h0);
    idle();
    drain();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_be();
    test_full();
    test_out_of_range();
    test_latency();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/obi_mem_responder.md
Name: obi_mem_responder

Overview:
- Synthesizable OBI 1.2 responder (memory slave). It is the far end of the OBI initiator ports that the MCU testbench exposes through the OBI interface.
- Accepts address-phase requests and performs word reads/writes with byte enables into an internal memory array.
- Returns in-order responses through a bounded response FIFO, with configurable latency and backpressure on rready.
- Used as a reference memory and as an RTL loopback partner for the OBI agent.

Parameters:
- ADDR_WIDTH, 32, width of addr_i.
- DATA_WIDTH, 32, data width; must be 32 (4 byte lanes).
- MEM_DEPTH, 1024, number of words in the memory; power of two.
- MAX_OUTSTANDING, 4, response FIFO depth; power of two, at least 1.
- RESP_LATENCY, 1, minimum number of cycles from grant to rvalid; at least 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  1  address-phase request.
- gnt_o  out  1  address-phase grant.
- addr_i  in  ADDR_WIDTH  byte address.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  4  byte enables.
- wdata_i  in  32  write data.
- rvalid_o  out  1  response valid.
- rready_i  in  1  response ready; tie to 1 if unused.
- rdata_o  out  32  read data.
- err_o  out  1  error response.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0. FIFO pointers, count and latency counters are cleared. Memory contents are NOT reset.
- Grant (combinational):
  - gnt_o = req_i && !rst_i && (count < MAX_OUTSTANDING || pop_this_cycle).
  - A request is accepted when req_i && gnt_o are both high at the clock edge.
- Word index and range:
  - Word index = addr_i[log2(MEM_DEPTH)+1:2]; addr_i[1:0] is ignored.
  - Out of range when addr_i >= 4*MEM_DEPTH.
- Write access:
  - On acceptance with we_i=1 and in range, byte lane i is updated only where be_i[i]=1.
  - The response entry is {rdata=0, err=0}.
- Read access:
  - On acceptance with we_i=0 and in range, the memory word is read at the accepting edge.
  - The response entry is {rdata=word, err=0}.
  - A read issued after an accepted write to the same word returns the written data, including back-to-back in consecutive cycles.
- Out-of-range access: no memory update; the response entry is {rdata=0, err=1}.
- Response FIFO:
  - Each entry also carries a latency countdown initialised to RESP_LATENCY-1.
  - Countdowns of all entries decrement each cycle until they reach 0.
  - rvalid_o=1 when the FIFO is not empty and the head countdown is 0.
  - rdata_o/err_o show the head entry while rvalid_o=1, and 0 otherwise.
- Response handshake:
  - A pop occurs when rvalid_o && rready_i.
  - While rvalid_o=1 and rready_i=0, rvalid_o, rdata_o and err_o hold stable (OBI rule).
- Latency: with RESP_LATENCY=1, grant at edge N means rvalid_o is high in the cycle after edge N. Throughput is one transaction per cycle when rready_i=1.
- Full condition: count == MAX_OUTSTANDING means gnt_o=0, unless a pop occurs in the same cycle. Simultaneous push and pop leaves count unchanged.
- Empty condition: rvalid_o=0; a new push becomes visible only after RESP_LATENCY cycles (no combinational bypass).
- Pointers wrap modulo MAX_OUTSTANDING. count ranges 0..MAX_OUTSTANDING and is ADDR-independent, log2(MAX)+1 bits wide.
- Reset mid-operation: all pending responses are discarded, and rvalid_o and gnt_o drop asynchronously. Writes already accepted remain in memory.
- req_i may be deasserted without a grant; no state changes.

Decomposition:
- Package obi_mem_responder_pkg holds:
  - obi_resp_t struct {logic [31:0] rdata; logic err;}.
  - Localparams for byte-lane count (4) and word-offset bits (2).
  - Function addr_in_range().
- Sub-module obi_resp_fifo: parameterised-depth FIFO of obi_resp_t plus latency countdown, with push/pop/full/empty/count. The top level holds the memory array, grant logic and address decode.

Test Plan:
- Reset, write then read: after rst_i pulse, write addr 0x10, be 4'hF, wdata 0xDEADBEEF; read 0x10 → rvalid one cycle after the read grant, rdata 0xDEADBEEF, err 0.
- Partial byte enables: word 0x20 preloaded with 0x11223344; write be 4'b0101, wdata 0xAABBCCDD; read → 0x11BB33DD.
- Backpressure/full: MAX_OUTSTANDING=4, rready_i=0, 6 back-to-back reads → exactly 4 grants, gnt_o=0 afterwards, rvalid_o/rdata_o stable. Raise rready_i → one pop per cycle, and grant resumes in the same cycle as the first pop.
- Out of range: MEM_DEPTH=1024, read 0x1000 → err 1, rdata 0. Write 0x1000 → err 1, and memory is unchanged at alias word 0.
- Latency: RESP_LATENCY=3, single read granted at edge N → rvalid_o first high after edge N+2. 3 back-to-back reads → 3 consecutive rvalid cycles.
- Reset mid-operation: 3 reads pending, assert rst_i asynchronously → rvalid_o and gnt_o go 0 immediately. After release, no stale responses appear, and a prior accepted write is still readable.
